// File: rtl/fp_mult_pipe.sv
// Three-stage IEEE-754 binary multiplier with valid/ready flow control,
// round-to-nearest-even, denormal inputs flushed to zero and exception flags.
module fp_mult_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 invalid
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned MW   = MAN_W + 1;
  localparam int unsigned PW   = 2 * MW;
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EMAX = (1 << EXP_W) - 1;

  localparam logic [1:0] CLS_FIN  = 2'd0;
  localparam logic [1:0] CLS_NAN  = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_ZERO = 2'd3;

  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  // Global advance: the whole pipe moves unless the output is blocked.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1 combinational: unpack and classify.
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic [1:0]       cls1_c;
  logic [EW-1:0]    e1_c;

  always_comb begin
    ea     = a[W-2 -: EXP_W];
    eb     = b[W-2 -: EXP_W];
    fa     = a[MAN_W-1:0];
    fb     = b[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EXP_ONES) && (fa == '0);
    b_inf  = (eb == EXP_ONES) && (fb == '0);
    a_nan  = (ea == EXP_ONES) && (fa != '0);
    b_nan  = (eb == EXP_ONES) && (fb != '0);
    cls1_c = CLS_FIN;
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      cls1_c = CLS_NAN;
    end else if (a_inf || b_inf) begin
      cls1_c = CLS_INF;
    end else if (a_zero || b_zero) begin
      cls1_c = CLS_ZERO;
    end
    // Two's complement sum held in EW bits; wraps correctly for negatives.
    e1_c = EW'(ea) + EW'(eb) - EW'(BIAS);
  end

  // Pipeline valid bits
  logic v1, v2;

  // Stage 1 registers
  logic          s1_sign;
  logic [1:0]    s1_cls;
  logic [EW-1:0] s1_e;
  logic [MW-1:0] s1_ma, s1_mb;

  // Stage 2 registers
  logic          s2_sign;
  logic [1:0]    s2_cls;
  logic [EW-1:0] s2_e;
  logic [PW-1:0] s2_p;

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign <= a[W-1] ^ b[W-1];
      s1_cls  <= cls1_c;
      s1_e    <= e1_c;
      s1_ma   <= {1'b1, fa};
      s1_mb   <= {1'b1, fb};
      s2_sign <= s1_sign;
      s2_cls  <= s1_cls;
      s2_e    <= s1_e;
      s2_p    <= PW'(s1_ma) * PW'(s1_mb);
    end
  end

  // Stage 3 combinational: normalise, round, range check, pack.
  logic [PW-1:0]    norm;
  logic [MW-1:0]    keep;
  logic             guard, sticky, rnd;
  logic [MW:0]      man_r;
  logic [EW-1:0]    e3;
  logic [MAN_W-1:0] frac3;
  logic             ovf_c, unf_c;
  logic [W-1:0]     res3_c;
  logic             ov3_c, un3_c, inv3_c;
  logic             unused_hidden;

  always_comb begin
    norm   = s2_p[PW-1] ? s2_p : {s2_p[PW-2:0], 1'b0};
    keep   = norm[PW-1 -: MW];
    guard  = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];
    rnd    = guard && (sticky || keep[0]);
    man_r  = {1'b0, keep} + (MW+1)'(rnd);
    e3     = s2_e + EW'(s2_p[PW-1]) + EW'(man_r[MW]);
    frac3  = man_r[MW] ? '0 : man_r[MAN_W-1:0];
    ovf_c  = !e3[EW-1] && (e3 >= EW'(EMAX));
    unf_c  = e3[EW-1] || (e3 == '0);
    res3_c = {s2_sign, e3[EXP_W-1:0], frac3};
    ov3_c  = 1'b0;
    un3_c  = 1'b0;
    inv3_c = 1'b0;
    case (s2_cls)
      CLS_NAN: begin
        res3_c = {1'b0, EXP_ONES, 1'b1, (MAN_W-1)'(0)};
        inv3_c = 1'b1;
      end
      CLS_INF:  res3_c = {s2_sign, EXP_ONES, MAN_W'(0)};
      CLS_ZERO: res3_c = {s2_sign, (W-1)'(0)};
      default: begin
        if (ovf_c) begin
          res3_c = {s2_sign, EXP_ONES, MAN_W'(0)};
          ov3_c  = 1'b1;
        end else if (unf_c) begin
          res3_c = {s2_sign, (W-1)'(0)};
          un3_c  = 1'b1;
        end
      end
    endcase
  end

  assign unused_hidden = man_r[MAN_W];

  // Valid bits and output stage are reset; in-flight work is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        result    <= res3_c;
        overflow  <= ov3_c;
        underflow <= un3_c;
        invalid   <= inv3_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed self-checking bench for fp_mult_pipe: FP32 vector table, back-pressure,
// mid-stream reset and a binary16 instance.
module tb_fp_mult_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ov;
    logic        un;
    logic        inv;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic        overflow, underflow, invalid;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_result;
  logic        h_overflow, h_underflow, h_invalid;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_n   = 0;

  vec_t vecs[15];
  vec_t exp_q[$];
  int   tick_q[$];
  vec_t idle;

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );

  fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .reset(reset),
    .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result),
    .overflow(h_overflow), .underflow(h_underflow), .invalid(h_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (tick %0d)", name, act, req, tick_n);
    end
  endtask

  // One cycle: drive at the falling edge, observe handshakes, advance to the next falling edge.
  task automatic tick(input logic iv, input vec_t v, input logic ordy, input bit chk_lat,
                      output bit acc);
    vec_t e;
    int   t0;
    in_valid  = iv;
    a         = v.a;
    b         = v.b;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious out_valid", 64'(out_valid), 64'(0));
      end else if (out_ready) begin
        e  = exp_q.pop_front();
        t0 = tick_q.pop_front();
        check("result+flags", 64'({result, overflow, underflow, invalid}),
              64'({e.res, e.ov, e.un, e.inv}));
        if (chk_lat) check("latency", 64'(tick_n - t0), 64'(3));
      end else begin
        e = exp_q[0];
        check("stall hold", 64'({result, overflow, underflow, invalid}),
              64'({e.res, e.ov, e.un, e.inv}));
      end
    end
    if (acc) begin
      exp_q.push_back(v);
      tick_q.push_back(tick_n);
    end
    @(negedge clk);
    tick_n++;
  endtask

  task automatic drain(input bit chk_lat);
    bit acc;
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) tick(1'b0, idle, 1'b1, chk_lat, acc);
    check("drain complete", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    bit acc;
    int idx;

    idle     = '{32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'hC0000000, 32'h40000000, 32'hC0800000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h3F800800, 32'h3F800800, 32'h3F801000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h80800000, 32'h00800000, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{32'h3FC00000, 32'hC0400000, 32'hC0900000, 1'b0, 1'b0, 1'b0};

    reset       = 1'b1;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    out_ready   = 1'b1;
    h_in_valid  = 1'b0;
    h_a         = '0;
    h_b         = '0;
    h_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset in_ready", 64'(in_ready), 64'(1));
    check("reset result", 64'(result), 64'(0));
    check("reset flags", 64'({overflow, underflow, invalid}), 64'(0));
    reset = 1'b0;

    // Back-to-back stream of the whole table, no back-pressure
    for (int i = 0; i < 15; i++) begin
      tick(1'b1, vecs[i], 1'b1, 1'b1, acc);
      check("stream accept", 64'(acc), 64'(1));
    end
    drain(1'b1);

    // Back-pressure: fill with out_ready low, then release
    idx = 0;
    for (int t = 0; t < 5; t++) begin
      tick(idx < 5, vecs[idx], 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    check("fill depth", 64'(idx), 64'(3));
    check("stalled in_ready", 64'(in_ready), 64'(0));
    check("stalled out_valid", 64'(out_valid), 64'(1));
    for (int r = 0; r < 5; r++) begin
      check("release no gap", 64'(out_valid), 64'(1));
      tick(idx < 5, vecs[idx], 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    check("release all issued", 64'(idx), 64'(5));
    check("release all returned", 64'(exp_q.size()), 64'(0));
    check("release drained", 64'(out_valid), 64'(0));

    // Reset mid-stream with two pairs in flight
    tick(1'b1, vecs[5], 1'b1, 1'b0, acc);
    tick(1'b1, vecs[6], 1'b1, 1'b0, acc);
    reset = 1'b1;
    tick(1'b0, idle, 1'b1, 1'b0, acc);
    reset = 1'b0;
    exp_q.delete();
    tick_q.delete();
    check("mid reset out_valid", 64'(out_valid), 64'(0));
    check("mid reset in_ready", 64'(in_ready), 64'(1));
    check("mid reset result", 64'(result), 64'(0));
    tick(1'b1, vecs[14], 1'b1, 1'b1, acc);
    check("post reset accept", 64'(acc), 64'(1));
    drain(1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, idle, 1'b1, 1'b0, acc);

    // binary16 instance
    h_in_valid = 1'b1;
    h_a        = 16'h4000;
    h_b        = 16'h4200;
    @(negedge clk);
    h_a = 16'h7BFF;
    h_b = 16'h4000;
    @(negedge clk);
    h_in_valid = 1'b0;
    @(negedge clk);
    check("fp16 6.0 valid", 64'(h_out_valid), 64'(1));
    check("fp16 6.0", 64'({h_result, h_overflow, h_underflow, h_invalid}),
          64'({16'h4600, 3'b000}));
    @(negedge clk);
    check("fp16 overflow valid", 64'(h_out_valid), 64'(1));
    check("fp16 overflow", 64'({h_result, h_overflow, h_underflow, h_invalid}),
          64'({16'h7C00, 3'b100}));
    @(negedge clk);
    check("fp16 empty", 64'(h_out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
